wishbone_lsu_master: RTL and testbench

//  Load/store bridge between the core's memory stage and the Wishbone data bus (upstream of urom/ram/IO slaves).

---
 rtl/wishbone_lsu_master.sv | 206 ++++++++++++++++++++
 tb/tb_wishbone_lsu_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_lsu_master.sv
// Load/store bridge: one core memory request becomes one Wishbone classic cycle with lane steering and load extension.
// Latency: 3 edges request-to-DONE with a zero-wait slave; misaligned/illegal requests error out after 1 edge without a bus cycle.
// Backpressure: the slave stalls via ACK; i_REQ is only sampled in IDLE. WB_TIMEOUT_EN adds a bus-abort watchdog.
module wishbone_lsu_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_REQ,
    input  logic                  i_WE,
    input  logic [2:0]            i_FUNCT3,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic                  o_ERR,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic                  o_CYC,
    output logic                  o_STB,
    output logic                  o_WE,
    output logic [ADDR_WIDTH-1:0] o_ADR,
    output logic [3:0]            o_SEL,
    output logic [DATA_WIDTH-1:0] o_DAT,
    input  logic [DATA_WIDTH-1:0] i_DAT,
    input  logic                  i_ACK
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              lane_q, lane_d;
    logic [DATA_WIDTH-1:0]   rbuf_q, rbuf_d;
    logic                    busy_d, done_d, err_d, cyc_d, stb_d, we_d;
    logic [DATA_WIDTH-1:0]   rdata_d, dat_d;
    logic [ADDR_WIDTH-1:0]   adr_d;
    logic [3:0]              sel_d;

`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          to_err_q, to_err_d;
`endif

    // BU/HU exist only as loads; 011 and 11x are never legal.
    function automatic logic req_ok(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'b000:  req_ok = 1'b1;
            3'b001:  req_ok = (lo[0] == 1'b0);
            3'b010:  req_ok = (lo == 2'b00);
            3'b100:  req_ok = !we;
            3'b101:  req_ok = !we && (lo[0] == 1'b0);
            default: req_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] sel_for(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   sel_for = 4'b0001 << lo;
            2'b01:   sel_for = 4'b0011 << lo;
            default: sel_for = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wdat_for(input logic [2:0] f3, input logic [DATA_WIDTH-1:0] wd);
        case (f3[1:0])
            2'b00:   wdat_for = {4{wd[7:0]}};
            2'b01:   wdat_for = {2{wd[15:0]}};
            default: wdat_for = wd;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                                       input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] s;
        s = d >> {lo, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
            3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
            3'b100:  load_ext = {24'd0, s[7:0]};
            3'b101:  load_ext = {16'd0, s[15:0]};
            default: load_ext = s;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        rbuf_d   = rbuf_q;
        cyc_d    = o_CYC;
        stb_d    = o_STB;
        we_d     = o_WE;
        adr_d    = o_ADR;
        sel_d    = o_SEL;
        dat_d    = o_DAT;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
`ifdef WB_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_err_d = to_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_REQ) begin
                    if (req_ok(i_WE, i_FUNCT3, i_ADDR[1:0])) begin
                        state_d  = S_BUS;
                        funct3_d = i_FUNCT3;
                        lane_d   = i_ADDR[1:0];
                        cyc_d    = 1'b1;
                        stb_d    = 1'b1;
                        we_d     = i_WE;
                        adr_d    = {i_ADDR[ADDR_WIDTH-1:2], 2'b00};
                        sel_d    = sel_for(i_FUNCT3, i_ADDR[1:0]);
                        dat_d    = wdat_for(i_FUNCT3, i_WDATA);
`ifdef WB_TIMEOUT_EN
                        to_cnt_d = '0;
                        to_err_d = 1'b0;
`endif
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (i_ACK) begin
                    rbuf_d  = o_WE ? '0 : load_ext(funct3_q, lane_q, i_DAT);
                    state_d = S_RESP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
`ifdef WB_TIMEOUT_EN
                end else if (to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rbuf_d   = '0;
                    to_err_d = 1'b1;
                    state_d  = S_RESP;
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = 4'b0000;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                rdata_d = rbuf_q;
`ifdef WB_TIMEOUT_EN
                err_d   = to_err_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            lane_q   <= '0;
            rbuf_q   <= '0;
            o_BUSY   <= 1'b0;
            o_DONE   <= 1'b0;
            o_ERR    <= 1'b0;
            o_RDATA  <= '0;
            o_CYC    <= 1'b0;
            o_STB    <= 1'b0;
            o_WE     <= 1'b0;
            o_ADR    <= '0;
            o_SEL    <= '0;
            o_DAT    <= '0;
`ifdef WB_TIMEOUT_EN
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            rbuf_q   <= rbuf_d;
            o_BUSY   <= busy_d;
            o_DONE   <= done_d;
            o_ERR    <= err_d;
            o_RDATA  <= rdata_d;
            o_CYC    <= cyc_d;
            o_STB    <= stb_d;
            o_WE     <= we_d;
            o_ADR    <= adr_d;
            o_SEL    <= sel_d;
            o_DAT    <= dat_d;
`ifdef WB_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_wishbone_lsu_master.sv
// Directed bench for wishbone_lsu_master with a behavioural slave whose ACK delay is programmable.
module tb_wishbone_lsu_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        busy, done, err, cyc, stb, wb_we, ack;
    logic [31:0] rdata, adr, wb_dat_o, slv_dat;
    logic [3:0]  sel;

    int          ack_delay = 0;
    int          wcnt      = 0;
    logic        force_ack = 1'b0;

    int          checks    = 0;
    int          failures  = 0;

    int          op_cycles;
    logic        op_saw_cyc, op_err, op_busy, op_we;
    logic [31:0] op_rdata, op_adr, op_dat;
    logic [3:0]  op_sel;

    always #5 clk = ~clk;

    wishbone_lsu_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .i_CLK(clk), .i_RST(rst_n), .i_REQ(req), .i_WE(we), .i_FUNCT3(f3),
        .i_ADDR(addr), .i_WDATA(wdata), .o_BUSY(busy), .o_DONE(done), .o_ERR(err),
        .o_RDATA(rdata), .o_CYC(cyc), .o_STB(stb), .o_WE(wb_we), .o_ADR(adr),
        .o_SEL(sel), .o_DAT(wb_dat_o), .i_DAT(slv_dat), .i_ACK(ack)
    );

    assign ack = force_ack | (cyc & stb & (wcnt >= ack_delay));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     wcnt <= 0;
        else if (!stb)  wcnt <= 0;
        else if (!ack)  wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request and follows it to DONE; 'now' skips the alignment wait for back-to-back issue.
    task automatic run_op(input logic now, input logic op_w, input logic [2:0] op_f3,
                          input logic [31:0] op_a, input logic [31:0] op_wd);
        logic fin;
        if (!now) @(negedge clk);
        req = 1'b1; we = op_w; f3 = op_f3; addr = op_a; wdata = op_wd;
        op_cycles = 0; op_saw_cyc = 1'b0; fin = 1'b0;
        op_rdata = '1; op_err = 1'bx; op_busy = 1'b0;
        for (int n = 0; n < 60 && !fin; n++) begin
            @(posedge clk);
            op_cycles++;
            @(negedge clk);
            req = 1'b0;
            if (cyc && !op_saw_cyc) begin
                op_saw_cyc = 1'b1;
                op_sel = sel; op_adr = adr; op_dat = wb_dat_o; op_we = wb_we; op_busy = busy;
            end
            if (done) begin
                fin = 1'b1;
                op_rdata = rdata;
                op_err = err;
            end
        end
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'd0; addr = '0; wdata = '0; slv_dat = '0;
        repeat (2) @(negedge clk);
        chk("rst_cyc",  {31'd0, cyc},  32'd0);
        chk("rst_stb",  {31'd0, stb},  32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out",  {rdata | adr | wb_dat_o}, 32'd0);
        chk("rst_sel",  {28'd0, sel},  32'd0);
        rst_n = 1'b1;

        // LW 0x100, zero-wait slave
        slv_dat = 32'hDEADBEEF;
        run_op(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_sel", {28'd0, op_sel}, 32'h0000000F);
        chk("lw_adr", op_adr, 32'h100);
        chk("lw_busy", {31'd0, op_busy}, 32'd1);
        chk("lw_lat", op_cycles, 32'd3);
        chk("lw_rdata", op_rdata, 32'hDEADBEEF);
        chk("lw_err", {31'd0, op_err}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);

        // LB / LBU from the top byte lane
        slv_dat = 32'h80112233;
        run_op(1'b0, 1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_sel", {28'd0, op_sel}, 32'h8);
        chk("lb_rdata", op_rdata, 32'hFFFFFF80);
        run_op(1'b0, 1'b0, 3'b100, 32'h103, 32'h0);
        chk("lbu_rdata", op_rdata, 32'h00000080);

        // LH / LHU low half, and LH upper half positive
        slv_dat = 32'h12348765;
        run_op(1'b0, 1'b0, 3'b001, 32'h100, 32'h0);
        chk("lh_sel", {28'd0, op_sel}, 32'h3);
        chk("lh_rdata", op_rdata, 32'hFFFF8765);
        run_op(1'b0, 1'b0, 3'b101, 32'h100, 32'h0);
        chk("lhu_rdata", op_rdata, 32'h00008765);
        slv_dat = 32'h7FFF8000;
        run_op(1'b0, 1'b0, 3'b001, 32'h102, 32'h0);
        chk("lh_hi_rdata", op_rdata, 32'h00007FFF);

        // SH 0x202
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD);
        chk("sh_we", {31'd0, op_we}, 32'd1);
        chk("sh_sel", {28'd0, op_sel}, 32'hC);
        chk("sh_dat", op_dat, 32'hABCDABCD);
        chk("sh_adr", op_adr, 32'h200);
        chk("sh_rdata", op_rdata, 32'd0);
        chk("sh_err", {31'd0, op_err}, 32'd0);

        // SB lane 1
        run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h1234565A);
        chk("sb_sel", {28'd0, op_sel}, 32'h2);
        chk("sb_dat", op_dat, 32'h5A5A5A5A);

        // misaligned and illegal requests
        run_op(1'b0, 1'b0, 3'b010, 32'h101, 32'h0);
        chk("lw_mis_cyc", {31'd0, op_saw_cyc}, 32'd0);
        chk("lw_mis_lat", op_cycles, 32'd1);
        chk("lw_mis_err", {31'd0, op_err}, 32'd1);
        chk("lw_mis_rdata", op_rdata, 32'd0);
        run_op(1'b0, 1'b0, 3'b001, 32'h103, 32'h0);
        chk("lh_mis_cyc", {31'd0, op_saw_cyc}, 32'd0);
        chk("lh_mis_err", {31'd0, op_err}, 32'd1);
        run_op(1'b0, 1'b0, 3'b011, 32'h100, 32'h0);
        chk("f3_011_err", {31'd0, op_err}, 32'd1);
        run_op(1'b0, 1'b1, 3'b100, 32'h100, 32'h0);
        chk("sbu_err", {31'd0, op_err}, 32'd1);
        chk("sbu_cyc", {31'd0, op_saw_cyc}, 32'd0);

        // back-to-back: second request issued in the DONE cycle
        slv_dat = 32'hCAFEF00D;
        run_op(1'b0, 1'b0, 3'b010, 32'h400, 32'h0);
        run_op(1'b1, 1'b0, 3'b010, 32'h404, 32'h0);
        chk("b2b_lat", op_cycles, 32'd3);
        chk("b2b_adr", op_adr, 32'h404);

        // slave wait states
        ack_delay = 2;
        run_op(1'b0, 1'b0, 3'b010, 32'h500, 32'h0);
        chk("wait_lat", op_cycles, 32'd5);
        chk("wait_rdata", op_rdata, 32'hCAFEF00D);

        // ACK outside a bus cycle must be ignored
        bad = 1'b0;
        @(negedge clk);
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || cyc) bad = 1'b1;
        end
        force_ack = 1'b0;
        chk("ack_idle", {31'd0, bad}, 32'd0);

        // reset in the middle of a stalled bus cycle
        ack_delay = 5;
        @(negedge clk);
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h600;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc",  {31'd0, cyc},  32'd0);
        chk("rst_mid_stb",  {31'd0, stb},  32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || cyc) bad = 1'b1;
        end
        chk("rst_mid_nodone", {31'd0, bad}, 32'd0);
        ack_delay = 0;
        slv_dat = 32'h0BADF00D;
        run_op(1'b0, 1'b0, 3'b010, 32'h600, 32'h0);
        chk("post_rst_rdata", op_rdata, 32'h0BADF00D);
        chk("post_rst_lat", op_cycles, 32'd3);

`ifdef WB_TIMEOUT_EN
        // slave never acknowledges: 8 BUS cycles, then RESP with error
        ack_delay = 1000;
        run_op(1'b0, 1'b0, 3'b010, 32'h700, 32'h0);
        chk("to_lat", op_cycles, 32'd10);
        chk("to_err", {31'd0, op_err}, 32'd1);
        chk("to_rdata", op_rdata, 32'd0);
        chk("to_cyc_low", {31'd0, cyc}, 32'd0);
        ack_delay = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
